signal_detect_mc: RTL
=====================

// Module: signal_detect_mc
// PURPOSE
//  Multi-channel run-length detector; next generation of the single-channel detector.
//  Per channel, per-cycle runtime mode: OWT (emit after DN_TH equal samples) or PWM
//  (emit on a closed run of legal width), plus timeout and overflow reporting.
//  Channel events are merged round-robin onto one valid/ready event stream to the decoder.
// PARAMETERS
//  CH_NUM  4   number of independent input channels (>=1)
//  CNT_W   10  run-length counter / threshold width
//  CH_W    $clog2(CH_NUM)>0 ? $clog2(CH_NUM) : 1 (derived, not overridable)
// PORTS
//  i_clk       in   1        clock
//  i_rst       in   1        asynchronous, active-high reset
//  i_vld       in   CH_NUM   per-channel sample valid
//  i_vld_data  in   CH_NUM   per-channel sample value
//  i_mode      in   CH_NUM   per-channel mode: 0 PWM, 1 OWT
//  i_dn_th     in   CNT_W    lower run threshold, shared by all channels
//  i_up_th     in   CNT_W    upper run threshold, shared by all channels
//  i_ovf_clr   in   CH_NUM   clear pulse for o_ovf
//  o_vld       out  1        event valid
//  o_vld_data  out  1        event level
//  o_ch_id     out  CH_W     channel that produced the event
//  i_rdy       in   1        downstream accepts event when o_vld & i_rdy
//  o_tmo       out  CH_NUM   1-cycle timeout pulse
//  o_ovf       out  CH_NUM   sticky: event dropped because channel slot full
//  o_cfg_err   out  1        registered (i_dn_th==0)|(i_dn_th>i_up_th)
// BEHAVIOUR
//  - Reset: cnt=0, last_vld=0, last_data=0, pending=0, o_vld=0, o_vld_data=0,
//    o_ch_id=0, o_tmo=0, o_ovf=0, o_cfg_err=0, rr pointer=0.
//  - Per channel on i_vld: same = last_vld & (i_vld_data==last_data);
//    len = same ? sat(cnt+1) : 1 (sat at 2^CNT_W-1); last_vld<=1, last_data<=i_vld_data.
//  - No i_vld: all channel state holds.
//  - OWT: if len==i_dn_th -> event(level=i_vld_data), cnt<=0; else cnt<=len.
//    A continuous level therefore emits once every i_dn_th samples.
//  - PWM: on i_vld & last_vld & !same, closed run L=cnt:
//    - i_dn_th<=L<=i_up_th -> event(level=last_data);
//    - otherwise no event.
//    - Timeout: same & len==i_up_th+1 -> o_tmo pulse next cycle; cnt saturates at
//      i_up_th+1, so one pulse per run. A timed-out run never emits.
//  - i_mode[c] change (edge vs registered copy): cnt<=0, last_vld<=0, pending kept.
//  - o_cfg_err=1: no events and no timeouts generated; counters still run.
//  - Pending: one slot per channel {vld,level}. Event sets the slot. If slot full and
//    not popped same cycle -> event dropped, o_ovf[c]<=1.
//    Pop and push same cycle -> new event stored, no overflow.
//  - Ovf clear: i_ovf_clr[c] clears o_ovf[c]; set wins on simultaneous set/clear.
//  - Output register loads when !o_vld | i_rdy: round-robin grant among pending
//    slots, starting at pointer; winner slot cleared; pointer<=winner+1 (mod CH_NUM).
//    No pending -> o_vld<=0.
//  - Output stability: o_vld_data/o_ch_id stable while o_vld & !i_rdy.
//  - Latency: sample edge t -> pending t+1 -> o_vld t+2 (output free, rr winner).
//  - Throughput: one event per cycle sustained.
//  - Mid-operation reset: drops all state immediately, pending events lost.
// STRUCTURE
//  - signal_detect_pkg:
//    - typedef enum logic {SD_PWM=1'b0, SD_OWT=1'b1} sd_mode_e;
//    - typedef struct packed {logic lvl;} sd_evt_t;
//  - Sub-module signal_detect_ch: one channel's cnt/last/mode/timeout logic,
//    outputs evt pulse + level + tmo; instantiated CH_NUM times via generate.
//  - Top: pending slots, ovf flags, round-robin arbiter, output register.
// TESTING
//  1 OWT ch0, dn=4 up=8, 8 samples of 1 -> two events (ch0,1) at sample 4 and 8,
//    each 2 cycles after its sample.
//  2 PWM ch1, dn=3 up=5: runs 1x4,0x2,1x6,0 -> one event (ch1,lvl1) after the 4-run;
//    0x2 dropped as glitch; o_tmo[1] pulses once at 6th 1; no event for that run.
//  3 All 4 channels OWT dn=2, identical stimulus, i_rdy=1 -> events ch0,ch1,ch2,ch3
//    in rr order on consecutive cycles.
//  4 i_rdy=0 with ch2 pending and output held -> second ch2 event sets o_ovf[2];
//    o_vld/o_ch_id/o_vld_data stable; i_ovf_clr[2] clears it.
//  5 dn=6 up=4 -> o_cfg_err=1, no o_vld or o_tmo for any stimulus;
//    restore dn=2 -> normal events.
//  6 Assert i_rst mid-run with pending events and o_vld=1 -> all outputs 0 at once;
//    a fresh run after release counts from 1.

Source files
------------

// File: rtl/signal_detect_pkg.sv
// Shared types for the multi-channel signal detector.
//   sd_mode_e : per-channel detection mode (PWM closed-run / OWT fixed-count)
//   sd_evt_t  : payload of one detected event (the run level)
package signal_detect_pkg;

    typedef enum logic {
        SD_PWM = 1'b0,
        SD_OWT = 1'b1
    } sd_mode_e;

    typedef struct packed {
        logic lvl;
    } sd_evt_t;

    // Channel-id width; never zero so a single-channel build still has a port.
    function automatic int sd_ch_w(input int n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/signal_detect_ch.sv
// One detector channel: run-length counter, last-sample tracking, mode-change
// restart and PWM timeout. Events are combinational pulses in the sample cycle;
// the timeout is registered (pulses the cycle after the offending sample).
//   i_clk, i_rst        clock, async active-high reset
//   i_vld, i_data       sample strobe and value
//   i_mode              0 PWM, 1 OWT
//   i_dn_th, i_up_th    run thresholds
//   i_cfg_err           registered threshold error; suppresses events/timeouts
//   o_evt, o_evt_data   event pulse and its level
//   o_tmo               registered timeout pulse
module signal_detect_ch
    import signal_detect_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    input  logic             i_data,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_dn_th,
    input  logic [CNT_W-1:0] i_up_th,
    input  logic             i_cfg_err,
    output logic             o_evt,
    output sd_evt_t          o_evt_data,
    output logic             o_tmo
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_vld_q, last_vld_d;
    logic             last_data_q, last_data_d;
    sd_mode_e         mode_q, mode_d;
    logic             tmo_q, tmo_d;

    logic             mode_chg;
    logic             eff_last_vld;
    logic [CNT_W-1:0] eff_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len;
    logic             same;
    logic [CNT_W:0]   up_p1;

    always_comb begin
        mode_d      = sd_mode_e'(i_mode);
        mode_chg    = (mode_d != mode_q);
        // A mode change restarts the channel; a sample arriving in that same
        // cycle is treated as the first sample of a fresh run.
        eff_last_vld = last_vld_q & ~mode_chg;
        eff_cnt      = mode_chg ? '0 : cnt_q;
        same         = eff_last_vld & (i_data == last_data_q);
        cnt_inc      = (eff_cnt == CNT_MAX) ? CNT_MAX : eff_cnt + 1'b1;
        len          = same ? cnt_inc : {{(CNT_W-1){1'b0}}, 1'b1};
        // One bit wider so i_up_th == max does not wrap to zero.
        up_p1        = {1'b0, i_up_th} + {{CNT_W{1'b0}}, 1'b1};

        cnt_d       = cnt_q;
        last_vld_d  = last_vld_q;
        last_data_d = last_data_q;
        tmo_d       = 1'b0;
        o_evt       = 1'b0;
        o_evt_data  = '0;

        if (mode_chg) begin
            cnt_d      = '0;
            last_vld_d = 1'b0;
        end

        if (i_vld) begin
            last_vld_d  = 1'b1;
            last_data_d = i_data;
            if (mode_d == SD_OWT) begin
                if (len == i_dn_th) begin
                    o_evt          = ~i_cfg_err;
                    o_evt_data.lvl = i_data;
                    cnt_d          = '0;
                end else begin
                    cnt_d = len;
                end
            end else if (same) begin
                // Counter parks at up+1 so a long run times out exactly once.
                if ({1'b0, eff_cnt} >= up_p1) begin
                    cnt_d = eff_cnt;
                end else begin
                    cnt_d = len;
                    tmo_d = ~i_cfg_err & ({1'b0, len} == up_p1);
                end
            end else begin
                cnt_d = len;
                if (eff_last_vld && (eff_cnt >= i_dn_th) && (eff_cnt <= i_up_th)) begin
                    o_evt          = ~i_cfg_err;
                    o_evt_data.lvl = last_data_q;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q       <= '0;
            last_vld_q  <= 1'b0;
            last_data_q <= 1'b0;
            mode_q      <= SD_PWM;
            tmo_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_vld_q  <= last_vld_d;
            last_data_q <= last_data_d;
            mode_q      <= mode_d;
            tmo_q       <= tmo_d;
        end
    end

    assign o_tmo = tmo_q;

endmodule

// File: rtl/signal_detect_mc.sv
// Multi-channel run-length detector. CH_NUM detector channels feed one
// single-entry pending slot each; a round-robin arbiter moves pending events
// into a single valid/ready output register.
//   i_clk, i_rst           clock, async active-high reset
//   i_vld, i_vld_data      per-channel sample strobe / value
//   i_mode                 per-channel mode (0 PWM, 1 OWT)
//   i_dn_th, i_up_th       shared run thresholds
//   i_ovf_clr              per-channel overflow clear
//   o_vld, o_vld_data,
//   o_ch_id, i_rdy         merged event stream
//   o_tmo                  per-channel timeout pulse
//   o_ovf                  per-channel sticky drop flag
//   o_cfg_err              registered threshold misconfiguration
module signal_detect_mc
    import signal_detect_pkg::*;
#(
    parameter  int CH_NUM = 4,
    parameter  int CNT_W  = 10,
    localparam int CH_W   = sd_ch_w(CH_NUM)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_NUM-1:0] i_vld,
    input  logic [CH_NUM-1:0] i_vld_data,
    input  logic [CH_NUM-1:0] i_mode,
    input  logic [CNT_W-1:0]  i_dn_th,
    input  logic [CNT_W-1:0]  i_up_th,
    input  logic [CH_NUM-1:0] i_ovf_clr,
    output logic              o_vld,
    output logic              o_vld_data,
    output logic [CH_W-1:0]   o_ch_id,
    input  logic              i_rdy,
    output logic [CH_NUM-1:0] o_tmo,
    output logic [CH_NUM-1:0] o_ovf,
    output logic              o_cfg_err
);

    logic [CH_NUM-1:0]          ch_evt;
    sd_evt_t [CH_NUM-1:0]       ch_evt_data;

    logic [CH_NUM-1:0]          pend_vld_q, pend_vld_d;
    sd_evt_t [CH_NUM-1:0]       pend_evt_q, pend_evt_d;
    logic [CH_NUM-1:0]          ovf_q, ovf_d;
    logic                       out_vld_q, out_vld_d;
    sd_evt_t                    out_evt_q, out_evt_d;
    logic [CH_W-1:0]            ch_id_q, ch_id_d;
    logic [CH_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                       cfg_err_q, cfg_err_d;

    logic                       load;
    logic                       found;
    logic [CH_W-1:0]            win;
    logic [CH_W:0]              idx;
    logic [CH_NUM-1:0]          pop;
    logic [CH_NUM-1:0]          ovf_set;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        signal_detect_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_vld      (i_vld[c]),
            .i_data     (i_vld_data[c]),
            .i_mode     (i_mode[c]),
            .i_dn_th    (i_dn_th),
            .i_up_th    (i_up_th),
            .i_cfg_err  (cfg_err_q),
            .o_evt      (ch_evt[c]),
            .o_evt_data (ch_evt_data[c]),
            .o_tmo      (o_tmo[c])
        );
    end

    assign cfg_err_d = (i_dn_th == '0) | (i_dn_th > i_up_th);

    // Round-robin arbiter and output register.
    always_comb begin
        load      = ~out_vld_q | i_rdy;
        found     = 1'b0;
        win       = '0;
        idx       = '0;
        pop       = '0;
        out_vld_d = out_vld_q;
        out_evt_d = out_evt_q;
        ch_id_d   = ch_id_q;
        rr_ptr_d  = rr_ptr_q;

        // Scan from the pointer, wrapping modulo CH_NUM; first pending wins.
        for (int i = 0; i < CH_NUM; i++) begin
            idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(CH_NUM)) begin
                idx = idx - (CH_W+1)'(CH_NUM);
            end
            if (!found && pend_vld_q[idx[CH_W-1:0]]) begin
                found = 1'b1;
                win   = idx[CH_W-1:0];
            end
        end

        if (load) begin
            out_vld_d = found;
            if (found) begin
                pop[win]  = 1'b1;
                out_evt_d = pend_evt_q[win];
                ch_id_d   = win;
                rr_ptr_d  = (win == CH_W'(CH_NUM-1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Pending slots: a pop frees the slot in the same cycle, so push+pop
    // never overflows.
    always_comb begin
        pend_vld_d = (pend_vld_q & ~pop) | ch_evt;
        pend_evt_d = pend_evt_q;
        for (int c = 0; c < CH_NUM; c++) begin
            if (ch_evt[c] && (!pend_vld_q[c] || pop[c])) begin
                pend_evt_d[c] = ch_evt_data[c];
            end
        end
        ovf_set = ch_evt & pend_vld_q & ~pop;
        ovf_d   = ovf_set | (ovf_q & ~i_ovf_clr);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_vld_q <= '0;
            pend_evt_q <= '0;
            ovf_q      <= '0;
            out_vld_q  <= 1'b0;
            out_evt_q  <= '0;
            ch_id_q    <= '0;
            rr_ptr_q   <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_evt_q <= pend_evt_d;
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_evt_q  <= out_evt_d;
            ch_id_q    <= ch_id_d;
            rr_ptr_q   <= rr_ptr_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign o_vld      = out_vld_q;
    assign o_vld_data = out_evt_q.lvl;
    assign o_ch_id    = ch_id_q;
    assign o_ovf      = ovf_q;
    assign o_cfg_err  = cfg_err_q;

endmodule
